// File: rtl/bit_scan_pkg.sv
// Shared definitions for the bit scanner: mode codes, FSM states and a sizing helper.
package bit_scan_pkg;

    localparam logic [1:0] MODE_ZEROS = 2'b00;
    localparam logic [1:0] MODE_ONES  = 2'b01;
    localparam logic [1:0] MODE_LZ    = 2'b10;
    localparam logic [1:0] MODE_TZ    = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    function automatic int unsigned ceil_div(input int unsigned n, input int unsigned d);
        return (n + d - 1) / d;
    endfunction

endpackage

// File: rtl/bit_chunk_eval.sv
// Combinational evaluation of one STEP-bit chunk: increment for the selected mode and a
// flag telling whether any valid bit is set.
module bit_chunk_eval
    import bit_scan_pkg::*;
#(
    parameter int unsigned STEP = 1,
    localparam int unsigned IW  = $clog2(STEP + 1)
) (
    input  logic [STEP-1:0] chunk,
    input  logic [STEP-1:0] valid,
    input  logic [1:0]      mode,
    output logic [IW-1:0]   inc,
    output logic            has_one
);

    logic seen;

    always_comb begin
        inc  = '0;
        seen = 1'b0;
        for (int unsigned i = 0; i < STEP; i++) begin
            if (valid[i]) begin
                unique case (mode)
                    MODE_ZEROS: if (!chunk[i]) inc = inc + IW'(1);
                    MODE_ONES:  if (chunk[i])  inc = inc + IW'(1);
                    default: begin
                        // Zero-run counting stops at the lowest set bit of the chunk.
                        if (!seen) begin
                            if (chunk[i]) seen = 1'b1;
                            else          inc  = inc + IW'(1);
                        end
                    end
                endcase
            end
        end
        has_one = |(chunk & valid);
    end

endmodule

// File: rtl/bit_scan_counter.sv
// Multi-cycle bit scanner: counts zeros, ones, leading or trailing zeros of a latched
// operand, STEP bits per cycle, with fixed latency and restart-on-start.
module bit_scan_counter
    import bit_scan_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned STEP  = 1,
    localparam int unsigned CW   = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] a,
    output logic [CW-1:0]    count,
    output logic             busy,
    output logic             done
);

    localparam int unsigned NCHUNK = ceil_div(WIDTH, STEP);
    localparam int unsigned PADW   = NCHUNK * STEP;
    localparam int unsigned IXW    = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int unsigned IW     = $clog2(STEP + 1);

    state_t           state_q, state_d;
    logic [1:0]       mode_q;
    logic [PADW-1:0]  op_q;
    logic [IXW-1:0]   idx_q;
    logic [CW-1:0]    count_q;
    logic             found_q;

    logic [WIDTH-1:0] a_rev;
    logic [STEP-1:0]  chunk;
    logic [STEP-1:0]  valid;
    logic [IW-1:0]    inc;
    logic             has_one;
    logic             last;
    logic [CW-1:0]    inc_eff;
    int unsigned      base;

    always_comb begin
        a_rev = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            a_rev[i] = a[WIDTH-1-i];
        end
    end

    always_comb begin
        base  = STEP * 32'(idx_q);
        chunk = STEP'(op_q >> base);
        valid = '0;
        // Bits beyond WIDTH in the final chunk are padding.
        for (int unsigned j = 0; j < STEP; j++) begin
            valid[j] = (base + j) < WIDTH;
        end
    end

    bit_chunk_eval #(
        .STEP (STEP)
    ) u_eval (
        .chunk   (chunk),
        .valid   (valid),
        .mode    (mode_q),
        .inc     (inc),
        .has_one (has_one)
    );

    assign last    = (idx_q == IXW'(NCHUNK - 1));
    assign inc_eff = (mode_q[1] && found_q) ? '0 : CW'(inc);

    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = RUN;
        end else if (state_q == RUN && last) begin
            state_d = DONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            mode_q  <= MODE_ZEROS;
            op_q    <= '0;
            idx_q   <= '0;
            count_q <= '0;
            found_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (start) begin
                mode_q  <= mode;
                op_q    <= PADW'((mode == MODE_LZ) ? a_rev : a);
                idx_q   <= '0;
                count_q <= '0;
                found_q <= 1'b0;
            end else if (state_q == RUN) begin
                count_q <= count_q + inc_eff;
                idx_q   <= idx_q + IXW'(1);
                if (has_one) found_q <= 1'b1;
            end
        end
    end

    assign count = count_q;
    assign busy  = (state_q == RUN);
    assign done  = (state_q == DONE);

endmodule

// File: tb/tb_bit_scan_counter.sv
// Directed bench for bit_scan_counter: STEP=1 and STEP=3 instances, WIDTH=8.
module tb_bit_scan_counter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start1 = 1'b0;
    logic       start3 = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [7:0] a = 8'h00;
    logic [3:0] count1, count3;
    logic       busy1, done1, busy3, done3;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    bit_scan_counter #(.WIDTH(8), .STEP(1)) dut1 (
        .clk (clk), .rst (rst), .start (start1), .mode (mode), .a (a),
        .count (count1), .busy (busy1), .done (done1)
    );

    bit_scan_counter #(.WIDTH(8), .STEP(3)) dut3 (
        .clk (clk), .rst (rst), .start (start3), .mode (mode), .a (a),
        .count (count3), .busy (busy3), .done (done3)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Returns at the falling edge following the accepting edge E0.
    task automatic do_start(input bit use3, input logic [1:0] m, input logic [7:0] v);
        @(negedge clk);
        mode = m;
        a    = v;
        if (use3) start3 = 1'b1;
        else      start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        start3 = 1'b0;
    endtask

    task automatic wait_done(input bit use3, output int n);
        n = 0;
        while (!(use3 ? done3 : done1) && n < 50) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic run_op(input string tag, input bit use3, input logic [1:0] m,
                          input logic [7:0] v, input int lat, input int exp_count);
        int n;
        do_start(use3, m, v);
        check({tag, "_busy"}, use3 ? busy3 : busy1, 1);
        wait_done(use3, n);
        check({tag, "_lat"}, n, lat);
        check({tag, "_count"}, use3 ? count3 : count1, exp_count);
    endtask

    initial begin
        #3;
        check("rst_count1", count1, 0);
        check("rst_busy1", busy1, 0);
        check("rst_done1", done1, 0);
        check("rst_count3", count3, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("idle_done1", done1, 0);

        // Basic counting, STEP=1
        run_op("t1_zeros", 0, 2'b00, 8'b1010_0000, 8, 6);
        run_op("t1_ones",  0, 2'b01, 8'b1010_0000, 8, 2);
        run_op("t2_lz",    0, 2'b10, 8'b0001_0000, 8, 3);
        run_op("t2_tz",    0, 2'b11, 8'b0001_0000, 8, 4);
        run_op("t2_lz0",   0, 2'b10, 8'h00, 8, 8);
        run_op("t2_tz0",   0, 2'b11, 8'h00, 8, 8);
        run_op("t2_lzmsb", 0, 2'b10, 8'h80, 8, 0);
        run_op("t2_tzlsb", 0, 2'b11, 8'h81, 8, 0);

        // STEP=3: three chunks, top chunk has one padding bit
        run_op("t3_zerosff", 1, 2'b00, 8'hFF, 3, 0);
        run_op("t3_zeros00", 1, 2'b00, 8'h00, 3, 8);
        run_op("t3_tz80",    1, 2'b11, 8'h80, 3, 7);
        run_op("t3_lz01",    1, 2'b10, 8'h01, 3, 7);
        run_op("t3_ones5a",  1, 2'b01, 8'h5A, 3, 4);
        run_op("t3_tz00",    1, 2'b11, 8'h00, 3, 8);

        // Restart mid-scan: no done from the aborted scan
        do_start(0, 2'b00, 8'h00);
        @(negedge clk);
        check("t4_done_e1", done1, 0);
        @(negedge clk);
        check("t4_part_e2", count1, 2);
        mode   = 2'b01;
        a      = 8'hFF;
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        mode   = 2'b00;
        a      = 8'h00;
        check("t4_restart_count", count1, 0);
        check("t4_restart_busy", busy1, 1);
        begin
            int n;
            wait_done(0, n);
            check("t4_lat", n, 8);
            check("t4_count", count1, 8);
        end

        // Asynchronous reset mid-scan, with start asserted under reset
        do_start(0, 2'b01, 8'hFF);
        @(negedge clk);
        @(negedge clk);
        check("t5_part", count1, 2);
        #2 rst = 1'b1;
        #1;
        check("t5_rst_count", count1, 0);
        check("t5_rst_busy", busy1, 0);
        check("t5_rst_done", done1, 0);
        start1 = 1'b1;
        @(negedge clk);
        check("t5_rst_wins", busy1, 0);
        start1 = 1'b0;
        rst    = 1'b0;
        repeat (3) @(negedge clk);
        check("t5_post_count", count1, 0);
        check("t5_post_busy", busy1, 0);
        check("t5_post_done", done1, 0);

        // Hold after done while inputs wander
        run_op("t6_tz", 0, 2'b11, 8'h10, 8, 4);
        for (int k = 0; k < 10; k++) begin
            a    = 8'($urandom);
            mode = 2'($urandom);
            @(negedge clk);
            check("t6_hold_count", count1, 4);
            check("t6_hold_done", done1, 1);
            check("t6_hold_busy", busy1, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
